ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the execute stage. Drives HI/LO into the
//  EX->MEM path (ExecResult for mfhi/mflo) feeding the memory-stage register.
//  One radix-2 step per clock for MULT/MULTU/DIV/DIVU.
//  Asserts qStall so the EX stage holds while an operation runs.
// PARAMETERS
//  WIDTH  32  operand width; iteration count; HI/LO width
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  dStart    in   1      issue pulse; accepted only when idle
//  dOp       in   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//  dSrcA     in   WIDTH  multiplicand / dividend; data for mthi/mtlo
//  dSrcB     in   WIDTH  multiplier / divisor
//  dMtHi     in   1      write dSrcA into HI (mthi)
//  dMtLo     in   1      write dSrcA into LO (mtlo)
//  qStall    out  1      operation in progress; EX holds issue
//  qDone     out  1      one-cycle pulse: new HI/LO valid
//  qDivZero  out  1      with qDone: last op was divide by zero
//  qHi       out  WIDTH  HI register
//  qLo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; qHi=qLo=0; qStall=qDone=qDivZero=0.
//  Reset mid-operation aborts it; no partial result reaches HI/LO.
//  FSM: IDLE -> RUN (dStart) -> FIX after WIDTH steps -> IDLE.
//  - IDLE: on edge with dStart=1, latch operand magnitudes, op, and sign flags.
//    Step counter = 0. Go RUN.
//  - RUN: one step per edge. Counter increments; at count WIDTH-1 go FIX.
//  - FIX: apply sign correction, write HI/LO, pulse qDone, go IDLE.
//  qStall is registered: it equals (state != IDLE).
//  Latency: start accepted at edge N; HI/LO updated and qDone=1 after edge
//    N+WIDTH+1 (33 cycles at WIDTH=32). qStall is high for cycles N+1..N+WIDTH+1.
//  qHi/qLo keep their old values during RUN. Working registers are internal.
//  dStart, dMtHi and dMtLo are ignored while qStall=1.
//  In IDLE, if dStart is asserted together with dMtHi/dMtLo, start wins and the
//    move is ignored. dMtHi and dMtLo together write both registers.
//  MULT/MULTU: {HI,LO} = full 2*WIDTH product.
//  - Shift-add on magnitudes (unsigned ops use raw operands).
//  - Signed result is negated in FIX when signA^signB.
//  - MULT -2^31 * -2^31: {HI,LO} = 0x40000000_00000000.
//  DIV/DIVU: restoring division on magnitudes; LO=quotient, HI=remainder.
//  - Quotient negated when signA^signB; remainder takes the sign of the dividend.
//  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).
//  - Divide by zero (signed or unsigned) still takes the full latency.
//    Result: LO = all ones, HI = dSrcA unchanged, qDivZero=1 with qDone.
//  qDivZero is 0 on any qDone that was not a divide by zero.
//  qDone and qDivZero fall to 0 on the cycle after the pulse.
//  All arithmetic uses WIDTH+1 bit adders for restoring compare; no overflow flags.
// TESTING
//  1. MULTU 7*6 -> qStall 33 cycles, then qDone; HI=0, LO=0x0000002A.
//  2. MULT 0xFFFFFFFD*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//     MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  3. DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIVU 100/7 -> LO=14, HI=2.
//     DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  4. DIVU 0x1234/0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x1234, qDivZero=1.
//     The next op clears qDivZero.
//  5. dStart plus new operands while busy -> ignored; original result unchanged.
//     mthi while busy -> HI unchanged. mtlo 0xABCD in IDLE -> LO=0xABCD next cycle.
//  6. rst_n low at cycle 10 of a MULT -> qStall=0, HI=LO=0 immediately, no qDone.
//     New MULTU 3*3 after release -> LO=9.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the execute stage.
// One shift-add (multiply) or restoring-subtract (divide) step per clock,
// then a fix-up cycle that applies signs and commits HI/LO.
//
// state | meaning
// IDLE  | waiting for dStart; mthi/mtlo accepted here
// RUN   | WIDTH iteration steps on operand magnitudes
// FIX   | sign correction, HI/LO write, qDone pulse
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dStart,
  input  logic [1:0]       dOp,
  input  logic [WIDTH-1:0] dSrcA,
  input  logic [WIDTH-1:0] dSrcB,
  input  logic             dMtHi,
  input  logic             dMtLo,
  output logic             qStall,
  output logic             qDone,
  output logic             qDivZero,
  output logic [WIDTH-1:0] qHi,
  output logic [WIDTH-1:0] qLo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_w_q, hi_w_d;
  logic [WIDTH-1:0] lo_w_q, lo_w_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] src_a_q, src_a_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             stall_q, stall_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;

  // Operand magnitudes; unsigned ops (dOp[0]=1) use the raw operands.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sign_a = ~dOp[0] & dSrcA[WIDTH-1];
  assign sign_b = ~dOp[0] & dSrcB[WIDTH-1];
  assign mag_a  = sign_a ? -dSrcA : dSrcA;
  assign mag_b  = sign_b ? -dSrcB : dSrcB;

  // One iteration step. The divide compare relies on rem < divisor, so the
  // top bit of the WIDTH+1 bit difference is the borrow (a zero divisor
  // breaks that invariant, but its result is overridden in FIX).
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_neg;
  assign mul_sum   = {1'b0, hi_w_q} + (lo_w_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_w_q, lo_w_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign prod      = {hi_w_q, lo_w_q};
  assign prod_neg  = -prod;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_w_d    = hi_w_q;
    lo_w_d    = lo_w_q;
    opnd_d    = opnd_q;
    src_a_d   = src_a_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (dStart) begin
          state_d   = RUN;
          cnt_d     = '0;
          div_d     = dOp[1];
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          dz_d      = (dSrcB == '0);
          src_a_d   = dSrcA;
          hi_w_d    = '0;
          // multiply: add |A| under control of |B| bits; divide: shift |A| out
          lo_w_d    = dOp[1] ? mag_a : mag_b;
          opnd_d    = dOp[1] ? mag_b : mag_a;
        end else begin
          if (dMtHi) hi_d = dSrcA;
          if (dMtLo) lo_d = dSrcA;
        end
      end
      RUN: begin
        if (div_q) begin
          hi_w_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          lo_w_d = {lo_w_q[WIDTH-2:0], div_ge};
        end else begin
          hi_w_d = mul_sum[WIDTH:1];
          lo_w_d = {mul_sum[0], lo_w_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q && dz_q) begin
          lo_d      = '1;
          hi_d      = src_a_q;
          divzero_d = 1'b1;
        end else if (div_q) begin
          lo_d = neg_q     ? -lo_w_q : lo_w_q;
          hi_d = rem_neg_q ? -hi_w_q : hi_w_q;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_d != IDLE);
  end

  // State and register update; reset aborts any running operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_w_q    <= '0;
      lo_w_q    <= '0;
      opnd_q    <= '0;
      src_a_q   <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      stall_q   <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_w_q    <= hi_w_d;
      lo_w_q    <= lo_w_d;
      opnd_q    <= opnd_d;
      src_a_q   <= src_a_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      stall_q   <= stall_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign qStall   = stall_q;
  assign qDone    = done_q;
  assign qDivZero = divzero_q;
  assign qHi      = hi_q;
  assign qLo      = lo_q;

endmodule
